// File: rtl/muldiv_pkg.sv
// Shared constants for the HI/LO multiply/divide sequencer: FSM encodings,
// default iteration counts and the counter width.
package muldiv_pkg;

    localparam int MUL_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF = 32;
    localparam int CNT_W          = 6;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'b00;
    localparam state_t ST_RUN  = 2'b01;
    localparam state_t ST_DONE = 2'b10;

endpackage

// File: rtl/muldiv_iter_cnt.sv
// Loadable down-counter tracking the remaining engine iterations.
// Load wins over enable; the count saturates at zero instead of wrapping.
module muldiv_iter_cnt
    import muldiv_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         zero
);

    logic [W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/muldiv_seq_ctrl.sv
// Sequencer for the iterative MIPS multiply/divide engine feeding HI/LO.
// Optional early divide-by-zero completion: define MULDIV_DIV0_EARLY_EN.
module muldiv_seq_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic MulStartE,
    input  logic DivStartE,
    input  logic DivZeroE,
    input  logic FlushE,
    input  logic HiLoUseD,
    output logic StallReq,
    output logic Busy,
    output logic EngLoad,
    output logic EngStep,
    output logic EngOpDiv,
    output logic HiLoWe,
    output logic DivZero
);

    state_t             state_d, state_q;
    logic               op_div_d, op_div_q;
    logic               div0_d, div0_q;
    logic               start;
    logic               div0_start;
    logic               cnt_en;
    logic               cnt_zero;
    logic [CNT_W-1:0]   cnt_load_val;
    logic [CNT_W-1:0]   cnt_val;
    logic               unused_cnt;

    // Gating with rst_n keeps EngLoad/StallReq quiet while reset is held.
    assign start = rst_n & (MulStartE | DivStartE) & ~FlushE & (state_q == ST_IDLE);

`ifdef MULDIV_DIV0_EARLY_EN
    assign div0_start = start & DivStartE & DivZeroE;
`else
    logic unused_div_zero;
    assign unused_div_zero = DivZeroE;
    assign div0_start      = 1'b0;
`endif

    always_comb begin
        cnt_load_val = CNT_W'(MUL_CYCLES - 1);
        if (div0_start) begin
            cnt_load_val = '0;
        end else if (DivStartE) begin
            cnt_load_val = CNT_W'(DIV_CYCLES - 1);
        end
    end

    assign cnt_en = (state_q == ST_RUN) & ~cnt_zero;

    muldiv_iter_cnt #(
        .W (CNT_W)
    ) u_iter_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .cnt      (cnt_val),
        .zero     (cnt_zero)
    );

    assign unused_cnt = ^cnt_val;

    // RUN lasts exactly N cycles because the counter starts at N-1.
    always_comb begin
        state_d  = state_q;
        op_div_d = op_div_q;
        div0_d   = div0_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_div_d = DivStartE;
                    div0_d   = div0_start;
                    state_d  = div0_start ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_zero) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_div_q <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_div_q <= op_div_d;
            div0_q   <= div0_d;
        end
    end

    // Stall drops in DONE: the HI/LO write lands as the consumer enters EX.
    assign StallReq = HiLoUseD & ((state_q == ST_RUN) | start);
    assign Busy     = (state_q != ST_IDLE);
    assign EngLoad  = start;
    assign EngStep  = (state_q == ST_RUN);
    assign EngOpDiv = op_div_q;
    assign HiLoWe   = (state_q == ST_DONE) & ~div0_q;
    assign DivZero  = (state_q == ST_DONE) & div0_q;

endmodule
